medidor_frecuencia: RTL

MEDIDOR_FRECUENCIA -- requirements
Module: medidor_frecuencia

---
 rtl/medidor_pkg.sv | 16 +
 rtl/sincronizador_flancos.sv | 39 +++
 rtl/medidor_frecuencia.sv | 133 +++++++++++++
 3 files changed

// File: rtl/medidor_pkg.sv
// Shared types and default constants for the frequency/duty meter.
package medidor_pkg;

  // Default counter width and timeout (1 s at 50 MHz)
  localparam int CNT_W_DEF          = 26;
  localparam int TIMEOUT_CICLOS_DEF = 50_000_000;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ESPERA   = 2'd1,
    MIDE     = 2'd2,
    EXPIRADO = 2'd3
  } estado_t;

endpackage

// File: rtl/sincronizador_flancos.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// edge detector. rise/fall are single-cycle pulses derived from flops only.
module sincronizador_flancos (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  // Next-state of the synchronizer chain and the previous-level flop
  always_comb begin
    meta_d = sig_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchronizer and edge-detector registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/medidor_frecuencia.sv
// Period and high-time meter for a slow asynchronous signal, counted in
// C_50Mhz cycles between synchronized rising edges, with a sticky timeout.
module medidor_frecuencia
  import medidor_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
  input  logic             C_50Mhz,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] periodo,
  output logic [CNT_W-1:0] alto,
  output logic             valido,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CICLOS);
  localparam logic [CNT_W-1:0] UNO    = CNT_W'(1);

  logic sig_sync, sube, baja;

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] contador_q, contador_d;
  logic [CNT_W-1:0] alto_tmp_q, alto_tmp_d;
  logic [CNT_W-1:0] periodo_q, periodo_d;
  logic [CNT_W-1:0] alto_q, alto_d;
  logic             valido_q, valido_d;
  logic             timeout_q, timeout_d;

  sincronizador_flancos u_sincronizador (
    .clk    (C_50Mhz),
    .rst    (reset),
    .sig_in (sig_in),
    .sync   (sig_sync),
    .rise   (sube),
    .fall   (baja)
  );

  // FSM next-state, counter and measurement output logic
  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    alto_tmp_d = alto_tmp_q;
    periodo_d  = periodo_q;
    alto_d     = alto_q;
    valido_d   = 1'b0;
    timeout_d  = timeout_q;

    if (!enable) begin
      // Measurements and the timeout flag are held while disabled
      estado_d   = IDLE;
      contador_d = '0;
    end else begin
      unique case (estado_q)
        IDLE: begin
          contador_d = '0;
          estado_d   = ESPERA;
        end
        ESPERA: begin
          if (sube) begin
            // First rise only arms the measurement
            contador_d = UNO;
            alto_tmp_d = '0;
            timeout_d  = 1'b0;
            estado_d   = MIDE;
          end else if (contador_q == LIMITE) begin
            contador_d = '0;
            timeout_d  = 1'b1;
            estado_d   = EXPIRADO;
          end else begin
            contador_d = contador_q + UNO;
          end
        end
        MIDE: begin
          if (sube) begin
            periodo_d  = contador_q;
            alto_d     = alto_tmp_q;
            valido_d   = 1'b1;
            timeout_d  = 1'b0;
            contador_d = UNO;
            alto_tmp_d = '0;
          end else if (contador_q == LIMITE) begin
            contador_d = '0;
            timeout_d  = 1'b1;
            estado_d   = EXPIRADO;
          end else begin
            contador_d = contador_q + UNO;
            if (baja && !sig_sync) begin
              alto_tmp_d = contador_q;
            end
          end
        end
        EXPIRADO: begin
          contador_d = '0;
          estado_d   = ESPERA;
        end
        default: begin
          contador_d = '0;
          estado_d   = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge C_50Mhz or posedge reset) begin
    if (reset) begin
      estado_q   <= IDLE;
      contador_q <= '0;
      alto_tmp_q <= '0;
      periodo_q  <= '0;
      alto_q     <= '0;
      valido_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      alto_tmp_q <= alto_tmp_d;
      periodo_q  <= periodo_d;
      alto_q     <= alto_d;
      valido_q   <= valido_d;
      timeout_q  <= timeout_d;
    end
  end

  assign periodo = periodo_q;
  assign alto    = alto_q;
  assign valido  = valido_q;
  assign timeout = timeout_q;

endmodule
